password_store_arbiter: RTL and testbench

- Arbitrates single-port access to the 4-digit password store between three requesters:
  - the password setter (writes),
  - the password validator (reads),
  - a display scanner (reads).
- Sequences each access as latch, access, response.
- Blocks writes while the lock is in lockdown.
- Sits between the requesters and the store. The store has a synchronous read (data appears one cycle after the address) and a synchronous write.

---
 rtl/password_store_arbiter.sv | 163 ++++++++++++++++
 tb/tb_password_store_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/password_store_arbiter.sv
// password_store_arbiter: single-port access sequencer for the 4-digit password
// store. Setter writes take priority (unless lockDown); validator and display
// reads share the port round-robin. Each access runs latch -> access -> response.
// Optional write readback check is enabled by defining PSA_READBACK_EN.
module password_store_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lockDown,
  input  logic              set_req,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [DATA_W-1:0] set_wdata,
  output logic              set_gnt,
  input  logic              val_req,
  input  logic [ADDR_W-1:0] val_addr,
  output logic              val_gnt,
  output logic              val_rvalid,
  output logic [DATA_W-1:0] val_rdata,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef PSA_READBACK_EN
  ,
  output logic              wr_err
`endif
);

`ifdef PSA_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RESP, S_VERIFY, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

  typedef enum logic [1:0] {OWN_SET, OWN_VAL, OWN_DSP} owner_t;

  state_t              state, state_n;
  owner_t              owner_q, pick_own;
  logic                rr_ptr;      // 0: validator wins a tie, 1: display wins
  logic                pick;
  logic [ADDR_W-1:0]   addr_q, pick_addr;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   val_rdata_q, dsp_rdata_q;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Arbitration: unlocked setter first, then readers by round-robin pointer
  always_comb begin
    pick      = 1'b0;
    pick_own  = OWN_VAL;
    pick_addr = val_addr;
    if (set_req && !lockDown) begin
      pick      = 1'b1;
      pick_own  = OWN_SET;
      pick_addr = set_addr;
    end else if (val_req && (!dsp_req || !rr_ptr)) begin
      pick      = 1'b1;
      pick_own  = OWN_VAL;
      pick_addr = val_addr;
    end else if (dsp_req) begin
      pick      = 1'b1;
      pick_own  = OWN_DSP;
      pick_addr = dsp_addr;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_n;
  end

  // Latch the winning request; only read grants move the pointer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner_q <= OWN_VAL;
      addr_q  <= '0;
      wdata_q <= '0;
      rr_ptr  <= 1'b0;
    end else if (state == S_IDLE && pick) begin
      owner_q <= pick_own;
      addr_q  <= pick_addr;
      if (pick_own == OWN_SET) wdata_q <= set_wdata;
      else                     rr_ptr  <= (pick_own == OWN_VAL);
    end
  end

  // Read data holding registers, refreshed on the owner's response cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      val_rdata_q <= '0;
      dsp_rdata_q <= '0;
    end else if (state == S_RESP) begin
      if (owner_q == OWN_VAL) val_rdata_q <= mem_rdata;
      if (owner_q == OWN_DSP) dsp_rdata_q <= mem_rdata;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    state_n    = state;
    set_gnt    = 1'b0;
    val_gnt    = 1'b0;
    dsp_gnt    = 1'b0;
    val_rvalid = 1'b0;
    dsp_rvalid = 1'b0;
    mem_we     = 1'b0;
    val_rdata  = val_rdata_q;
    dsp_rdata  = dsp_rdata_q;
    busy       = (state != S_IDLE);
`ifdef PSA_READBACK_EN
    wr_err     = 1'b0;
`endif
    case (state)
      S_IDLE: if (pick) state_n = S_ACCESS;
      S_ACCESS: begin
        set_gnt = (owner_q == OWN_SET);
        val_gnt = (owner_q == OWN_VAL);
        dsp_gnt = (owner_q == OWN_DSP);
        if (owner_q == OWN_SET) begin
          mem_we  = 1'b1;
`ifdef PSA_READBACK_EN
          state_n = S_VERIFY;
`else
          state_n = S_IDLE;
`endif
        end else begin
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        // Data is forwarded straight from the store this cycle
        if (owner_q == OWN_VAL) begin
          val_rvalid = 1'b1;
          val_rdata  = mem_rdata;
        end
        if (owner_q == OWN_DSP) begin
          dsp_rvalid = 1'b1;
          dsp_rdata  = mem_rdata;
        end
        state_n = S_IDLE;
      end
`ifdef PSA_READBACK_EN
      S_VERIFY: state_n = S_CHECK;  // address still on mem_addr, we low
      S_CHECK: begin
        wr_err  = (mem_rdata != wdata_q);
        state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_password_store_arbiter.sv
// Testbench for password_store_arbiter: directed scenarios followed by random
// request rounds checked against a transaction-level model (digit array plus
// "whose turn" variable). Covers PSA_READBACK_EN when that macro is defined.
module tb_password_store_arbiter;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam logic [DW-1:0] INIT [4] = '{4'd3, 4'd1, 4'd4, 4'd1};
  localparam int G_SET = 4, G_VAL = 2, G_DSP = 1;

  logic          CLK = 1'b0, RST = 1'b1, lockDown = 1'b0;
  logic          set_req = 1'b0, val_req = 1'b0, dsp_req = 1'b0;
  logic [AW-1:0] set_addr = '0, val_addr = '0, dsp_addr = '0;
  logic [DW-1:0] set_wdata = '0;
  logic          set_gnt, val_gnt, val_rvalid, dsp_gnt, dsp_rvalid;
  logic [DW-1:0] val_rdata, dsp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we, busy;
  logic [DW-1:0] mem_rdata = '0;
`ifdef PSA_READBACK_EN
  logic          wr_err;
`endif

  // Environment store and its control
  logic [DW-1:0] store [4];
  logic          load = 1'b0;
  logic          stuck_en = 1'b0;

  // Reference model
  logic [DW-1:0] ref_mem [4];
  int            ref_ptr;      // 0: validator's turn on a tie, 1: display's
  int            n_checks = 0, n_err = 0;

  password_store_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .lockDown(lockDown),
    .set_req(set_req), .set_addr(set_addr), .set_wdata(set_wdata), .set_gnt(set_gnt),
    .val_req(val_req), .val_addr(val_addr), .val_gnt(val_gnt),
    .val_rvalid(val_rvalid), .val_rdata(val_rdata),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt),
    .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef PSA_READBACK_EN
    , .wr_err(wr_err)
`endif
  );

  always #5 CLK = ~CLK;

  // Synchronous-read store; stuck_en models bit 3 of address 0 stuck at 0
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 4; i++) store[i] <= INIT[i];
    end else if (mem_we) begin
      store[mem_addr] <= (stuck_en && mem_addr == 0) ? (mem_wdata & 4'h7) : mem_wdata;
    end
    mem_rdata <= store[mem_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gv();
    return {29'd0, set_gnt, val_gnt, dsp_gnt};
  endfunction

  function automatic logic [31:0] rv();
    return {30'd0, val_rvalid, dsp_rvalid};
  endfunction

  // Called in a write's grant cycle; returns in the next arbitration cycle
  task automatic wr_done();
`ifdef PSA_READBACK_EN
    tick();
    chk("verify_busy", 32'(busy), 1);
    chk("verify_we", 32'(mem_we), 0);
    tick();
    chk("check_wr_err", 32'(wr_err), 0);
`endif
    tick();
    chk("wr_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int nv, found, win, exp_g, exp_r;
    logic [AW-1:0] ra;

    // ---- reset state ----
    #1 RST = 1'b0;
    load = 1'b1;
    #1;
    chk("rst_gnt", gv(), 0);
    chk("rst_rvalid", rv(), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_val_rdata", 32'(val_rdata), 0);
    chk("rst_dsp_rdata", 32'(dsp_rdata), 0);
`ifdef PSA_READBACK_EN
    chk("rst_wr_err", 32'(wr_err), 0);
`endif
    tick();
    tick();
    load = 1'b0;
    RST  = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[i] = INIT[i];
    ref_ptr = 0;

    // ---- single read: addr 2 holds 4 ----
    val_req = 1'b1; val_addr = 2'd2;
    tick();
    chk("rd_gnt", gv(), G_VAL);
    chk("rd_busy1", 32'(busy), 1);
    chk("rd_addr", 32'(mem_addr), 2);
    chk("rd_we", 32'(mem_we), 0);
    val_req = 1'b0;
    tick();
    chk("rd_rvalid", rv(), G_VAL);
    chk("rd_data", 32'(val_rdata), 4);
    chk("rd_busy2", 32'(busy), 1);
    tick();
    chk("rd_done_busy", 32'(busy), 0);
    chk("rd_done_rvalid", rv(), 0);
    chk("rd_hold", 32'(val_rdata), 4);
    ref_ptr = 1;

    // ---- write then read back through display ----
    set_req = 1'b1; set_addr = 2'd1; set_wdata = 4'd7;
    tick();
    chk("wr_gnt", gv(), G_SET);
    chk("wr_we", 32'(mem_we), 1);
    chk("wr_addr", 32'(mem_addr), 1);
    chk("wr_data", 32'(mem_wdata), 7);
    set_req = 1'b0;
    ref_mem[1] = 4'd7;
    wr_done();
    chk("wr_we_low", 32'(mem_we), 0);
    dsp_req = 1'b1; dsp_addr = 2'd1;
    tick();
    chk("wr_rd_gnt", gv(), G_DSP);
    dsp_req = 1'b0;
    tick();
    chk("wr_rd_rvalid", rv(), G_DSP);
    chk("wr_rd_data", 32'(dsp_rdata), 7);
    tick();
    ref_ptr = 0;

    // ---- contention: grants alternate every 3 cycles ----
    val_req = 1'b1; val_addr = 2'd0;
    dsp_req = 1'b1; dsp_addr = 2'd3;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_g = (c % 3 == 1) ? (((c / 3) % 2 == 0) ? G_VAL : G_DSP) : 0;
      exp_r = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? G_VAL : G_DSP) : 0;
      chk("cont_gnt", gv(), 32'(exp_g));
      chk("cont_rvalid", rv(), 32'(exp_r));
      if (exp_r == G_VAL) chk("cont_val_data", 32'(val_rdata), 32'(ref_mem[0]));
      if (exp_r == G_DSP) chk("cont_dsp_data", 32'(dsp_rdata), 32'(ref_mem[3]));
    end
    set_req = 1'b1; set_addr = 2'd3; set_wdata = 4'd9;
    tick();
    chk("cont_set_wins", gv(), G_SET);
    chk("cont_set_addr", 32'(mem_addr), 3);
    set_req = 1'b0;
    ref_mem[3] = 4'd9;
    wr_done();
    tick();
    chk("cont_after_wr", gv(), G_VAL);
    val_req = 1'b0;
    tick();
    chk("cont_after_val", 32'(val_rdata), 32'(ref_mem[0]));
    tick();
    tick();
    chk("cont_after_dsp_gnt", gv(), G_DSP);
    dsp_req = 1'b0;
    tick();
    chk("cont_after_dsp", 32'(dsp_rdata), 32'(ref_mem[3]));
    tick();
    ref_ptr = 0;

    // ---- lockdown: setter held off, reads still served ----
    lockDown = 1'b1;
    set_req = 1'b1; set_addr = 2'd2; set_wdata = 4'd5;
    val_req = 1'b1; val_addr = 2'd1;
    nv = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("lock_no_set_gnt", 32'(set_gnt), 0);
      if (val_gnt) nv++;
    end
    chk("lock_reads", 32'(nv), 4);
    lockDown = 1'b0;
    val_req = 1'b0;
    found = 0;
    for (int k = 0; k < 4 && found == 0; k++) begin
      tick();
      if (set_gnt) found = 1;
    end
    chk("unlock_set_gnt", 32'(found), 1);
    if (found == 1) begin
      chk("unlock_addr", 32'(mem_addr), 2);
      chk("unlock_data", 32'(mem_wdata), 5);
      set_req = 1'b0;
      ref_mem[2] = 4'd5;
      wr_done();
    end else begin
      set_req = 1'b0;
      repeat (6) tick();
    end
    ref_ptr = 1;

    // ---- reset in the middle of a read ----
    val_req = 1'b1; val_addr = 2'd1;
    tick();
    chk("mid_gnt", gv(), G_VAL);
    val_req = 1'b0;
    RST = 1'b0;
    #1;
    chk("mid_rst_gnt", gv(), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_rdata", 32'(val_rdata), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    tick();
    RST = 1'b1;
    chk("mid_rel_rvalid", rv(), 0);
    chk("mid_rel_busy", 32'(busy), 0);
    tick();
    chk("mid_rel_rvalid2", rv(), 0);
    chk("mid_rel_busy2", 32'(busy), 0);
    ref_ptr = 0;
    val_req = 1'b1; val_addr = 2'd2;
    dsp_req = 1'b1; dsp_addr = 2'd3;
    tick();
    chk("mid_ptr_val", gv(), G_VAL);
    val_req = 1'b0;
    tick();
    chk("mid_val_data", 32'(val_rdata), 32'(ref_mem[2]));
    tick();
    tick();
    chk("mid_dsp_gnt", gv(), G_DSP);
    dsp_req = 1'b0;
    tick();
    chk("mid_dsp_data", 32'(dsp_rdata), 32'(ref_mem[3]));
    tick();
    ref_ptr = 0;

    // ---- random rounds; each starts in an arbitration cycle ----
    for (int r = 0; r < 150; r++) begin
      if (!set_req && $urandom_range(0, 2) == 0) begin
        set_req = 1'b1; set_addr = 2'($urandom_range(0, 3)); set_wdata = 4'($urandom_range(0, 15));
      end
      if (!val_req && $urandom_range(0, 1) == 0) begin
        val_req = 1'b1; val_addr = 2'($urandom_range(0, 3));
      end
      if (!dsp_req && $urandom_range(0, 1) == 0) begin
        dsp_req = 1'b1; dsp_addr = 2'($urandom_range(0, 3));
      end
      lockDown = ($urandom_range(0, 3) == 0);
      if (set_req && !lockDown)   win = G_SET;
      else if (val_req && dsp_req) win = (ref_ptr == 0) ? G_VAL : G_DSP;
      else if (val_req)            win = G_VAL;
      else if (dsp_req)            win = G_DSP;
      else                         win = 0;
      tick();
      chk("rnd_gnt", gv(), 32'(win));
      if (win == 0) begin
        chk("rnd_idle_busy", 32'(busy), 0);
      end else if (win == G_SET) begin
        chk("rnd_wr_we", 32'(mem_we), 1);
        chk("rnd_wr_addr", 32'(mem_addr), 32'(set_addr));
        chk("rnd_wr_data", 32'(mem_wdata), 32'(set_wdata));
        ref_mem[set_addr] = set_wdata;
        set_req = 1'b0;
        wr_done();
      end else begin
        ra = (win == G_VAL) ? val_addr : dsp_addr;
        chk("rnd_rd_addr", 32'(mem_addr), 32'(ra));
        if (win == G_VAL) begin val_req = 1'b0; ref_ptr = 1; end
        else              begin dsp_req = 1'b0; ref_ptr = 0; end
        tick();
        chk("rnd_rvalid", rv(), 32'(win));
        chk("rnd_rdata", (win == G_VAL) ? 32'(val_rdata) : 32'(dsp_rdata), 32'(ref_mem[ra]));
        tick();
        chk("rnd_rd_idle", 32'(busy), 0);
      end
    end
    set_req = 1'b0; val_req = 1'b0; dsp_req = 1'b0; lockDown = 1'b0;
    repeat (5) tick();

`ifdef PSA_READBACK_EN
    // ---- readback: stuck bit at addr 0 flagged in cycle 3 ----
    stuck_en = 1'b1;
    set_req = 1'b1; set_addr = 2'd0; set_wdata = 4'hF;
    tick();
    chk("rb_gnt", gv(), G_SET);
    set_req = 1'b0;
    tick();
    chk("rb_c2_err", 32'(wr_err), 0);
    chk("rb_c2_busy", 32'(busy), 1);
    tick();
    chk("rb_c3_err", 32'(wr_err), 1);
    tick();
    chk("rb_c4_err", 32'(wr_err), 0);
    chk("rb_c4_busy", 32'(busy), 0);
    set_req = 1'b1; set_addr = 2'd1; set_wdata = 4'hA;
    tick();
    set_req = 1'b0;
    tick();
    tick();
    chk("rb_good_err", 32'(wr_err), 0);
    tick();
    stuck_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
